// File: rtl/aes_word_stream_if.sv
// 32-bit word-stream wrapper around AES_top. It assembles the key and data
// words into 128-bit buses, holds AES_en until the result strobe, and then
// returns the result as four words over a valid/ready port.
module aes_word_stream_if #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 8
) (
   input  logic         AES_clk,
   input  logic         AES_rst,
   input  logic [31:0]  s_word,
   input  logic         s_is_key,
   input  logic         s_valid,
   output logic         s_ready,
   output logic         AES_en,
   output logic [127:0] AES_data_in,
   output logic [127:0] AES_key_in,
   input  logic [127:0] AES_data_out,
   input  logic         AES_data_out_valid,
   output logic [31:0]  m_word,
   output logic         m_valid,
   input  logic         m_ready,
   output logic         m_last,
   output logic         busy,
   output logic         timeout_err
);

   typedef enum logic [1:0] {StLoad, StRun, StDrain} state_t;

   state_t       state_q, state_d;
   logic         s_ready_q, s_ready_d;
   logic         aes_en_q, aes_en_d;
   logic         busy_q, busy_d;
   logic [127:0] data_q, data_d;
   logic [127:0] key_q, key_d;
   logic [1:0]   key_cnt_q, key_cnt_d;
   logic [2:0]   data_cnt_q, data_cnt_d;
   logic         key_valid_q, key_valid_d;
   logic [CNT_W-1:0] cyc_q, cyc_d;
   // Words 1..3 of the result still waiting to be sent; word 0 goes straight to m_word.
   logic [95:0]  out_sr_q, out_sr_d;
   logic [1:0]   word_idx_q, word_idx_d;
   logic [31:0]  m_word_q, m_word_d;
   logic         m_valid_q, m_valid_d;
   logic         m_last_q, m_last_d;
   logic         timeout_err_q, timeout_err_d;

   logic         s_acc;
   logic         launch;

   assign s_acc  = s_valid & s_ready_q;
   assign launch = (data_cnt_q == 3'd4) & key_valid_q & (key_cnt_q == 2'd0);

   // Next-state and registered-output computation.
   always_comb begin
      state_d       = state_q;
      data_d        = data_q;
      key_d         = key_q;
      key_cnt_d     = key_cnt_q;
      data_cnt_d    = data_cnt_q;
      key_valid_d   = key_valid_q;
      cyc_d         = cyc_q;
      out_sr_d      = out_sr_q;
      word_idx_d    = word_idx_q;
      m_word_d      = m_word_q;
      m_valid_d     = m_valid_q;
      m_last_d      = m_last_q;
      timeout_err_d = timeout_err_q;

      unique case (state_q)
         StLoad: begin
            if (s_acc) begin
               if (s_is_key) begin
                  key_d     = {key_q[95:0], s_word};
                  key_cnt_d = key_cnt_q + 2'd1;
                  // A new key sequence invalidates the old key until it completes.
                  if (key_cnt_q == 2'd0) key_valid_d = 1'b0;
                  if (key_cnt_q == 2'd3) key_valid_d = 1'b1;
               end else if (data_cnt_q != 3'd4) begin
                  data_d     = {data_q[95:0], s_word};
                  data_cnt_d = data_cnt_q + 3'd1;
               end
            end
            if (launch) begin
               state_d = StRun;
               cyc_d   = '0;
            end
         end
         StRun: begin
            if (AES_data_out_valid) begin
               out_sr_d      = AES_data_out[95:0];
               m_word_d      = AES_data_out[127:96];
               m_valid_d     = 1'b1;
               m_last_d      = 1'b0;
               word_idx_d    = 2'd0;
               timeout_err_d = 1'b0;
               state_d       = StDrain;
            end else if (cyc_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               timeout_err_d = 1'b1;
               data_cnt_d    = 3'd0;
               state_d       = StLoad;
            end else if (cyc_q != {CNT_W{1'b1}}) begin
               cyc_d = cyc_q + CNT_W'(1);
            end
         end
         StDrain: begin
            if (m_valid_q && m_ready) begin
               if (word_idx_q == 2'd3) begin
                  m_valid_d  = 1'b0;
                  m_last_d   = 1'b0;
                  data_cnt_d = 3'd0;
                  state_d    = StLoad;
               end else begin
                  word_idx_d = word_idx_q + 2'd1;
                  m_word_d   = out_sr_q[95:64];
                  out_sr_d   = {out_sr_q[63:0], 32'h0};
                  m_last_d   = (word_idx_q == 2'd2);
               end
            end
         end
         default: state_d = StLoad;
      endcase

      // Status outputs follow the next state so they change on the transition edge.
      s_ready_d = (state_d == StLoad);
      aes_en_d  = (state_d == StRun);
      busy_d    = (state_d != StLoad);
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge AES_clk or posedge AES_rst) begin
      if (AES_rst) begin
         state_q       <= StLoad;
         s_ready_q     <= 1'b0;
         aes_en_q      <= 1'b0;
         busy_q        <= 1'b0;
         data_q        <= '0;
         key_q         <= '0;
         key_cnt_q     <= 2'd0;
         data_cnt_q    <= 3'd0;
         key_valid_q   <= 1'b0;
         cyc_q         <= '0;
         out_sr_q      <= '0;
         word_idx_q    <= 2'd0;
         m_word_q      <= '0;
         m_valid_q     <= 1'b0;
         m_last_q      <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         s_ready_q     <= s_ready_d;
         aes_en_q      <= aes_en_d;
         busy_q        <= busy_d;
         data_q        <= data_d;
         key_q         <= key_d;
         key_cnt_q     <= key_cnt_d;
         data_cnt_q    <= data_cnt_d;
         key_valid_q   <= key_valid_d;
         cyc_q         <= cyc_d;
         out_sr_q      <= out_sr_d;
         word_idx_q    <= word_idx_d;
         m_word_q      <= m_word_d;
         m_valid_q     <= m_valid_d;
         m_last_q      <= m_last_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign s_ready     = s_ready_q;
   assign AES_en      = aes_en_q;
   assign busy        = busy_q;
   assign AES_data_in = data_q;
   assign AES_key_in  = key_q;
   assign m_word      = m_word_q;
   assign m_valid     = m_valid_q;
   assign m_last      = m_last_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_aes_word_stream_if.sv
// Directed testbench for aes_word_stream_if with a behavioural AES_top stand-in.
module tb_aes_word_stream_if;

   logic         AES_clk = 1'b0;
   logic         AES_rst;
   logic [31:0]  s_word;
   logic         s_is_key;
   logic         s_valid;
   logic         s_ready;
   logic         AES_en;
   logic [127:0] AES_data_in;
   logic [127:0] AES_key_in;
   logic [127:0] AES_data_out;
   logic         AES_data_out_valid;
   logic [31:0]  m_word;
   logic         m_valid;
   logic         m_ready;
   logic         m_last;
   logic         busy;
   logic         timeout_err;

   int checks = 0;
   int errors = 0;

   localparam logic [127:0] KEY  = 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc;
   localparam logic [127:0] DATA = 128'h0000001b_00000000_00000000_00000000;
   localparam logic [127:0] RES  = 128'ha6f2daeb_140fa720_529e75d5_21cbc681;
   localparam logic [127:0] D2   = 128'hd7b26248_e8351227_5573a1e5_e8f263b3;
   localparam logic [127:0] RES2 = 128'h3925841d_02dc09fb_dc118597_196a0b32;

   always #5 AES_clk = ~AES_clk;

   aes_word_stream_if #(
      .TIMEOUT_CYCLES(255),
      .CNT_W         (8)
   ) dut (
      .AES_clk           (AES_clk),
      .AES_rst           (AES_rst),
      .s_word            (s_word),
      .s_is_key          (s_is_key),
      .s_valid           (s_valid),
      .s_ready           (s_ready),
      .AES_en            (AES_en),
      .AES_data_in       (AES_data_in),
      .AES_key_in        (AES_key_in),
      .AES_data_out      (AES_data_out),
      .AES_data_out_valid(AES_data_out_valid),
      .m_word            (m_word),
      .m_valid           (m_valid),
      .m_ready           (m_ready),
      .m_last            (m_last),
      .busy              (busy),
      .timeout_err       (timeout_err)
   );

   task automatic tick;
      @(posedge AES_clk);
      #1;
   endtask

   // Offer one word and return just after the edge that accepted it.
   task automatic send_word(input logic [31:0] w, input logic is_key);
      int n;
      n = 0;
      s_word   = w;
      s_is_key = is_key;
      s_valid  = 1'b1;
      while (!s_ready && n < 20) begin
         tick();
         n++;
      end
      if (!s_ready) begin
         errors++;
         $display("FAIL send_word_timeout: s_ready=%b required 1", s_ready);
      end
      tick();
      s_valid = 1'b0;
   endtask

   task automatic send_block(input logic [127:0] v, input logic is_key);
      for (int i = 0; i < 4; i++) send_word(v[127-32*i -: 32], is_key);
   endtask

   task automatic strobe_after(input logic [127:0] res, input int d);
      repeat (d) tick();
      AES_data_out       = res;
      AES_data_out_valid = 1'b1;
      tick();
      AES_data_out_valid = 1'b0;
      AES_data_out       = '0;
   endtask

   task automatic pulse_reset;
      AES_rst = 1'b1;
      tick();
      AES_rst = 1'b0;
      tick();
   endtask

   // Launch check, called right after the 4th data beat edge.
   task automatic test_launch(input logic [127:0] k, input logic [127:0] d);
      checks++;
      if (AES_en !== 1'b0) begin
         errors++; $display("FAIL launch_early: AES_en=%b required 0", AES_en);
      end
      tick();
      checks++;
      if (AES_en !== 1'b1 || s_ready !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL launch_flags: en=%b s_ready=%b busy=%b required 1 0 1",
                  AES_en, s_ready, busy);
      end
      checks++;
      if (AES_key_in !== k) begin
         errors++; $display("FAIL launch_key: got %h required %h", AES_key_in, k);
      end
      checks++;
      if (AES_data_in !== d) begin
         errors++; $display("FAIL launch_data: got %h required %h", AES_data_in, d);
      end
   endtask

   task automatic test_drain(input logic [127:0] exp, input logic [3:0] pat);
      int hs;
      int cyc;
      hs  = 0;
      cyc = 0;
      while (hs < 4 && cyc < 40) begin
         m_ready = pat[3 - (cyc % 4)];
         checks++;
         if (m_valid !== 1'b1 || m_word !== exp[127-32*hs -: 32] ||
             m_last !== (hs == 3)) begin
            errors++;
            $display("FAIL drain_word%0d: valid=%b word=%h last=%b required 1 %h %b",
                     hs, m_valid, m_word, m_last, exp[127-32*hs -: 32], hs == 3);
         end
         tick();
         if (m_ready) hs++;
         cyc++;
      end
      m_ready = 1'b0;
      checks++;
      if (hs != 4) begin
         errors++; $display("FAIL drain_count: got %0d handshakes required 4", hs);
      end
      checks++;
      if (m_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0 || m_last !== 1'b0) begin
         errors++;
         $display("FAIL drain_end: valid=%b s_ready=%b busy=%b last=%b required 0 1 0 0",
                  m_valid, s_ready, busy, m_last);
      end
      repeat (3) tick();
      checks++;
      if (m_valid !== 1'b0) begin
         errors++; $display("FAIL drain_extra: m_valid=%b required 0", m_valid);
      end
   endtask

   task automatic test_reset;
      AES_rst = 1'b1;
      repeat (2) tick();
      checks++;
      if (s_ready !== 1'b0 || AES_en !== 1'b0 || busy !== 1'b0 || m_valid !== 1'b0 ||
          m_last !== 1'b0 || timeout_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: rdy=%b en=%b busy=%b mv=%b last=%b to=%b required 0",
                  s_ready, AES_en, busy, m_valid, m_last, timeout_err);
      end
      checks++;
      if (AES_key_in !== '0 || AES_data_in !== '0 || m_word !== '0) begin
         errors++;
         $display("FAIL reset_buses: key=%h data=%h word=%h required 0",
                  AES_key_in, AES_data_in, m_word);
      end
      AES_rst = 1'b0;
      tick();
      checks++;
      if (s_ready !== 1'b1) begin
         errors++; $display("FAIL reset_release: s_ready=%b required 1", s_ready);
      end
   endtask

   task automatic test_first_block;
      int dropped;
      dropped = 0;
      send_block(KEY, 1'b1);
      send_block(DATA, 1'b0);
      test_launch(KEY, DATA);
      repeat (39) begin
         tick();
         if (AES_en !== 1'b1) dropped++;
      end
      checks++;
      if (dropped != 0) begin
         errors++; $display("FAIL run_hold: AES_en low %0d cycles required 0", dropped);
      end
      strobe_after(RES, 0);
      checks++;
      if (AES_en !== 1'b0 || m_valid !== 1'b1 || m_word !== RES[127:96]) begin
         errors++;
         $display("FAIL capture: en=%b mv=%b word=%h required 0 1 %h",
                  AES_en, m_valid, m_word, RES[127:96]);
      end
      test_drain(RES, 4'b1111);
   endtask

   task automatic test_stall;
      send_block(DATA, 1'b0);
      test_launch(KEY, DATA);
      strobe_after(RES, 40);
      test_drain(RES, 4'b1001);
   endtask

   task automatic test_back_to_back;
      send_block(D2, 1'b0);
      test_launch(KEY, D2);
      strobe_after(RES2, 10);
      test_drain(RES2, 4'b1111);
   endtask

   task automatic test_timeout;
      int n;
      int mv;
      n  = 0;
      mv = 0;
      send_block(DATA, 1'b0);
      test_launch(KEY, DATA);
      while (AES_en && n < 300) begin
         n++;
         if (m_valid) mv++;
         tick();
      end
      checks++;
      if (n != 255) begin
         errors++; $display("FAIL timeout_len: AES_en high %0d cycles required 255", n);
      end
      checks++;
      if (timeout_err !== 1'b1 || mv != 0 || m_valid !== 1'b0 || s_ready !== 1'b1 ||
          busy !== 1'b0) begin
         errors++;
         $display("FAIL timeout_flags: to=%b mv=%0d rdy=%b busy=%b required 1 0 1 0",
                  timeout_err, mv, s_ready, busy);
      end
      send_block(DATA, 1'b0);
      test_launch(KEY, DATA);
      checks++;
      if (timeout_err !== 1'b1) begin
         errors++; $display("FAIL timeout_sticky: timeout_err=%b required 1", timeout_err);
      end
      strobe_after(RES, 5);
      checks++;
      if (timeout_err !== 1'b0) begin
         errors++; $display("FAIL timeout_clear: timeout_err=%b required 0", timeout_err);
      end
      test_drain(RES, 4'b1111);
   endtask

   // Half-loaded key blocks launch; extra data beats are dropped.
   task automatic test_partial_key;
      send_word(KEY[127:96], 1'b1);
      send_word(KEY[95:64], 1'b1);
      send_block(DATA, 1'b0);
      send_word(32'hdeadbeef, 1'b0);
      repeat (5) tick();
      checks++;
      if (AES_en !== 1'b0 || s_ready !== 1'b1) begin
         errors++;
         $display("FAIL partial_key_block: en=%b rdy=%b required 0 1", AES_en, s_ready);
      end
      checks++;
      if (AES_data_in !== DATA) begin
         errors++; $display("FAIL extra_data: got %h required %h", AES_data_in, DATA);
      end
      send_word(KEY[63:32], 1'b1);
      send_word(KEY[31:0], 1'b1);
      test_launch(KEY, DATA);
      strobe_after(RES2, 3);
      test_drain(RES2, 4'b1111);
   endtask

   task automatic test_reset_run;
      send_block(DATA, 1'b0);
      test_launch(KEY, DATA);
      repeat (5) tick();
      AES_rst = 1'b1;
      #1;
      checks++;
      if (AES_en !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0 || m_valid !== 1'b0 ||
          AES_key_in !== '0 || AES_data_in !== '0) begin
         errors++;
         $display("FAIL reset_run: en=%b busy=%b rdy=%b mv=%b required 0",
                  AES_en, busy, s_ready, m_valid);
      end
      tick();
      AES_rst = 1'b0;
      #1;
      checks++;
      if (s_ready !== 1'b0) begin
         errors++; $display("FAIL reset_run_rdy_early: s_ready=%b required 0", s_ready);
      end
      tick();
      checks++;
      if (s_ready !== 1'b1) begin
         errors++; $display("FAIL reset_run_rdy: s_ready=%b required 1", s_ready);
      end
      send_block(DATA, 1'b0);
      repeat (10) tick();
      checks++;
      if (AES_en !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL reset_run_nokey: en=%b busy=%b required 0", AES_en, busy);
      end
   endtask

   task automatic test_reset_drain;
      pulse_reset();
      send_block(KEY, 1'b1);
      send_block(DATA, 1'b0);
      test_launch(KEY, DATA);
      strobe_after(RES, 5);
      m_ready = 1'b1;
      repeat (2) tick();
      m_ready = 1'b0;
      checks++;
      if (m_word !== RES[63:32] || m_valid !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_word: word=%h mv=%b required %h 1", m_word, m_valid,
                  RES[63:32]);
      end
      AES_rst = 1'b1;
      #1;
      checks++;
      if (m_valid !== 1'b0 || m_word !== '0 || m_last !== 1'b0 || busy !== 1'b0 ||
          s_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_drain: mv=%b word=%h last=%b busy=%b rdy=%b required 0",
                  m_valid, m_word, m_last, busy, s_ready);
      end
      tick();
      AES_rst = 1'b0;
      tick();
      checks++;
      if (s_ready !== 1'b1) begin
         errors++; $display("FAIL reset_drain_rdy: s_ready=%b required 1", s_ready);
      end
      send_block(DATA, 1'b0);
      repeat (10) tick();
      checks++;
      if (AES_en !== 1'b0 || m_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_drain_nokey: en=%b mv=%b required 0", AES_en, m_valid);
      end
   endtask

   initial begin
      AES_rst            = 1'b1;
      s_word             = '0;
      s_is_key           = 1'b0;
      s_valid            = 1'b0;
      m_ready            = 1'b0;
      AES_data_out       = '0;
      AES_data_out_valid = 1'b0;
      test_reset();
      test_first_block();
      test_stall();
      test_back_to_back();
      test_timeout();
      test_partial_key();
      test_reset_run();
      test_reset_drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/aes_word_stream_if.md
Name: aes_word_stream_if

Overview:
- 32-bit streaming front/back end for AES_top.
- Assembles four key words and four data words into the 128-bit AES_key_in and AES_data_in buses, then holds AES_en high until AES_top reports AES_data_out_valid.
- Captures AES_data_out and returns it as four 32-bit words over a valid/ready interface.
- Sits directly upstream and downstream of AES_top, between AES_top and the system word bus.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles in RUN waiting for AES_data_out_valid before abort.
- CNT_W, 8: width of the RUN cycle counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- AES_clk  in  1  clock, rising edge.
- AES_rst  in  1  asynchronous, active-high reset.
- s_word  in  32  input word.
- s_is_key  in  1  1 = key word, 0 = data word; qualified by s_valid.
- s_valid  in  1  input word valid.
- s_ready  out  1  input word accepted when s_valid & s_ready.
- AES_en  out  1  enable to AES_top.
- AES_data_in  out  128  assembled plaintext to AES_top.
- AES_key_in  out  128  assembled key to AES_top.
- AES_data_out  in  128  result from AES_top.
- AES_data_out_valid  in  1  result strobe from AES_top.
- m_word  out  32  output word.
- m_valid  out  1  output word valid.
- m_ready  in  1  output word consumed when m_valid & m_ready.
- m_last  out  1  high on the 4th output word.
- busy  out  1  high in RUN or DRAIN.
- timeout_err  out  1  sticky abort flag.

Behaviour:
- Reset (asynchronous): the following clear to 0:
  - outputs: s_ready, AES_en, AES_data_in, AES_key_in, m_word, m_valid, m_last, busy, timeout_err;
  - internal: key_cnt, data_cnt, key_valid, cycle counter;
  - state = LOAD.
- s_ready is registered. It is 0 while AES_rst is high and rises on the first clock edge after deassertion. Reset asserted mid-operation aborts immediately; no output words are emitted.
- Word order for every 128-bit value: the first word is bits [127:96], the last word is bits [31:0]. Load by shift-in, {reg[95:0], s_word}.
- State LOAD (s_ready = 1):
  - Key beat: shifts into AES_key_in and increments key_cnt modulo 4.
    - key_valid clears when a key beat is accepted with key_cnt = 0.
    - key_valid sets when the 4th key beat is accepted.
  - Data beat with data_cnt < 4: shifts into AES_data_in and increments data_cnt.
  - Data beat with data_cnt = 4: accepted and discarded.
  - Launch condition: data_cnt = 4 & key_valid & key_cnt = 0, evaluated on the registered values. When met, go to RUN and s_ready = 0 on the same edge.
  - Latency: 4th data beat at edge N (with the key already complete) -> AES_en = 1 after edge N+1.
- State RUN:
  - Outputs: AES_en = 1, busy = 1, s_ready = 0.
  - AES_data_in and AES_key_in are frozen. The cycle counter increments each cycle from 0.
  - AES_data_out_valid sampled high: capture AES_data_out into the output shift register, AES_en = 0, m_valid = 1, m_word = captured[127:96] on the same edge, go to DRAIN. timeout_err clears on this edge.
  - Counter reaches TIMEOUT_CYCLES with no strobe: AES_en = 0, timeout_err = 1, data_cnt = 0, go to LOAD. The key is retained.
  - AES_data_out_valid is ignored in LOAD and DRAIN.
- State DRAIN (busy = 1):
  - m_word and m_valid are held stable while m_valid & !m_ready.
  - Each handshake shifts the next word out.
  - m_last = 1 only with the 4th word.
  - On the 4th handshake: m_valid = 0, data_cnt = 0, go to LOAD, s_ready = 1 on the same edge. key_valid is retained.
- A key reload between blocks is allowed. A partially loaded key (key_cnt != 0) blocks launch until completed.
- The cycle counter saturates and never wraps.

Test Plan:
- Key words aa2bdb40, bff6a5e8, caa9ba3e, bc1e2acc, then data words 0000001b, 00000000, 00000000, 00000000.
  -> AES_key_in = aa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc and AES_data_in = 0000001b_000..0 at launch.
  -> AES_en rises one cycle after the 4th data beat and stays high until the strobe.
- Model AES_top returns a6f2daeb_140fa720_529e75d5_21cbc681 with a strobe 40 cycles after AES_en rises.
  -> m_word sequence a6f2daeb, 140fa720, 529e75d5, 21cbc681; m_last on the 4th; AES_en = 0 the cycle after the strobe.
- Same as above with m_ready toggling 1-0-0-1.
  -> m_word is held stable while stalled; exactly 4 handshakes; s_ready returns to 1 after the 4th.
- Second block d7b26248_e8351227_5573a1e5_e8f263b3 with no key reload.
  -> launch uses the retained key; no s_is_key beats are needed.
- Model never strobes, TIMEOUT_CYCLES = 255.
  -> AES_en falls after 255 RUN cycles, timeout_err = 1, m_valid never asserts; the next successful block clears timeout_err.
- AES_rst pulsed during RUN and during DRAIN (after 2 words).
  -> all outputs 0 immediately; s_ready = 1 one edge after release; key_valid = 0, so a data-only block does not launch.
